// File: rtl/mm_req_arbiter_pkg.sv
// Shared types for the main-memory request arbiter.
// Contents: data width, request/response structs, the arbiter FSM state
// enum and a helper that sizes requester index fields.
package mm_req_arbiter_pkg;

    localparam int unsigned MM_DATA_WIDTH = 128;
    localparam int unsigned MM_ADDR_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic                     we;
        logic [MM_ADDR_WIDTH-1:0] addr;
        logic [MM_DATA_WIDTH-1:0] wdata;
    } mm_req_t;

    typedef struct packed {
        logic                     valid;
        logic [MM_DATA_WIDTH-1:0] rdata;
    } mm_res_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRes
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_req_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
//   up_req    : per-requester request (valid, we, addr, wdata)
//   up_ready  : per-requester accept strobe
//   up_res    : per-requester response (valid, rdata)
//   mem_req   : request towards main memory
//   mem_ready : memory accepts mem_req this cycle
//   mem_res   : response from main memory
// Modports: slave = arbiter, master = environment (requesters + memory).
interface mm_req_arbiter_if
    import mm_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_OF_REQS = 4
) ();

    mm_req_t [NUM_OF_REQS-1:0] up_req;
    logic    [NUM_OF_REQS-1:0] up_ready;
    mm_res_t [NUM_OF_REQS-1:0] up_res;
    mm_req_t                   mem_req;
    logic                      mem_ready;
    mm_res_t                   mem_res;

    modport slave (
        input  up_req,
        output up_ready,
        output up_res,
        output mem_req,
        input  mem_ready,
        input  mem_res
    );

    modport master (
        output up_req,
        input  up_ready,
        input  up_res,
        input  mem_req,
        output mem_ready,
        output mem_res
    );

endinterface

// File: rtl/mm_rr_picker.sv
// Combinational requester picker.
//   req_i   : request vector
//   start_i : first index searched (round-robin mode)
//   gnt_o   : one-hot grant, zero when nothing requests
//   idx_o   : index of the granted requester
// Macro MM_ARB_FIXED_PRIO_EN: when defined, lowest index always wins and
// start_i is ignored.
module mm_rr_picker
    import mm_req_arbiter_pkg::*;
#(
    parameter int unsigned  NumReqs = 4,
    localparam int unsigned IdxW    = idx_width(NumReqs)
) (
    input  logic [NumReqs-1:0] req_i,
    input  logic [IdxW-1:0]    start_i,
    output logic [NumReqs-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o
);

    logic            found;
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

`ifdef MM_ARB_FIXED_PRIO_EN
    logic unused_start;
    assign unused_start = ^start_i;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumReqs; k++) begin
            cand     = k;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end
`else
    // Walk the ring starting at start_i; first requester found wins.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NumReqs; k++) begin
            cand     = (32'(start_i) + k) % NumReqs;
            cand_idx = IdxW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end
`endif

endmodule

// File: rtl/mm_req_arbiter.sv
// Main-memory request arbiter: shares one memory port among NUM_OF_REQS
// requesters with at most one transaction outstanding.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus_io : mm_req_arbiter_if.slave (up_req/up_ready/up_res, mem_req/
//            mem_ready/mem_res)
// Macro MM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead
// of round-robin; the last-winner register is then not built.
module mm_req_arbiter
    import mm_req_arbiter_pkg::*;
#(
    parameter int unsigned NUM_OF_REQS = 4
) (
    input logic              clk,
    input logic              rst,
    mm_req_arbiter_if.slave  bus_io
);

    localparam int unsigned IdxW = idx_width(NUM_OF_REQS);

    arb_state_e               state_q, state_d;
    logic [IdxW-1:0]          owner_q, owner_d;
    mm_req_t                  req_q, req_d;
    logic                     res_vld_q, res_vld_d;
    logic [MM_DATA_WIDTH-1:0] res_data_q, res_data_d;

    logic [NUM_OF_REQS-1:0]   req_vec;
    logic [NUM_OF_REQS-1:0]   gnt;
    logic [IdxW-1:0]          gnt_idx;
    logic [IdxW-1:0]          start;
    logic                     accept;
    logic [NUM_OF_REQS-1:0]   up_ready;
    mm_req_t                  mem_req;
    mm_res_t [NUM_OF_REQS-1:0] up_res;

    for (genvar g = 0; g < NUM_OF_REQS; g++) begin : g_req_vec
        assign req_vec[g] = bus_io.up_req[g].valid;
    end

    // No grant while reset is asserted.
    assign accept = (state_q == StIdle) && (|req_vec) && !rst;

`ifdef MM_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IdxW-1:0] last_q, last_d;

    assign start = (last_q == IdxW'(NUM_OF_REQS - 1)) ? '0 : last_q + IdxW'(1);
    assign last_d = accept ? gnt_idx : last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IdxW'(NUM_OF_REQS - 1);
        end else begin
            last_q <= last_d;
        end
    end
`endif

    mm_rr_picker #(
        .NumReqs (NUM_OF_REQS)
    ) u_picker (
        .req_i   (req_vec),
        .start_i (start),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_d         = req_q;
        res_vld_d     = 1'b0;
        res_data_d    = res_data_q;
        up_ready      = '0;
        mem_req       = req_q;
        mem_req.valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    up_ready = gnt;
                    req_d    = bus_io.up_req[gnt_idx];
                    owner_d  = gnt_idx;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                mem_req.valid = 1'b1;
                if (bus_io.mem_ready) begin
                    state_d = StWaitRes;
                end
            end
            StWaitRes: begin
                if (bus_io.mem_res.valid) begin
                    res_vld_d  = 1'b1;
                    res_data_d = bus_io.mem_res.rdata;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response is registered, so it reaches the owner one cycle after memory.
    always_comb begin
        up_res = '0;
        for (int unsigned j = 0; j < NUM_OF_REQS; j++) begin
            if (res_vld_q && (owner_q == IdxW'(j))) begin
                up_res[j].valid = 1'b1;
                up_res[j].rdata = res_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            req_q      <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
        end
    end

    assign bus_io.up_ready = up_ready;
    assign bus_io.mem_req  = mem_req;
    assign bus_io.up_res   = up_res;

endmodule

// File: tb/tb_mm_req_arbiter.sv
// Self-checking bench for mm_req_arbiter (NUM_OF_REQS = 4).
// Honors MM_ARB_FIXED_PRIO_EN in its arbitration model.
module tb_mm_req_arbiter;
    import mm_req_arbiter_pkg::*;

    localparam int unsigned N      = 4;
    localparam int          Budget = 40;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   model_last;
    mm_req_t sb [N];

    mm_req_arbiter_if #(.NUM_OF_REQS(N)) bus ();

    mm_req_arbiter #(
        .NUM_OF_REQS (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MM_DATA_WIDTH-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic mm_req_t mk_req(input logic we, input logic [31:0] addr,
                                       input logic [MM_DATA_WIDTH-1:0] wdata);
        mm_req_t r;
        r.valid = 1'b1;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [N-1:0] valid_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = bus.up_req[i].valid;
        return v;
    endfunction

    function automatic logic [N-1:0] res_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = bus.up_res[i].valid;
        return v;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: lowest index, or first requester after the last winner.
    function automatic int model_pick(input logic [N-1:0] v);
`ifdef MM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (model_last + k) % N;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.up_req    = '0;
        bus.mem_ready = 1'b0;
        bus.mem_res   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // Wait until some up_ready rises; the winner then drops its valid.
    task automatic wait_accept(output int idx, output logic [N-1:0] rdy, output int waited,
                               output bit timeout);
        idx     = -1;
        rdy     = '0;
        waited  = 0;
        timeout = 1'b1;
        for (int c = 0; c < Budget; c++) begin
            #1;
            if (bus.up_ready != '0) begin
                rdy = bus.up_ready;
                for (int i = N - 1; i >= 0; i--) if (rdy[i]) idx = i;
                waited  = c;
                timeout = 1'b0;
                tick();
                bus.up_req[idx].valid = 1'b0;
                return;
            end
            tick();
        end
    endtask

    // Hold mem_ready low for `stall` cycles, then accept.
    task automatic issue_phase(input int stall, output mm_req_t first, output bit stable,
                               output bit stray, output bit rdy_seen);
        mm_req_t cur;
        stable   = 1'b1;
        stray    = 1'b0;
        rdy_seen = 1'b0;
        first    = '0;
        for (int c = 0; c <= stall; c++) begin
            bus.mem_ready = (c == stall);
            #1;
            cur = bus.mem_req;
            if (c == 0) first = cur;
            else if (cur !== first) stable = 1'b0;
            if (cur.valid !== 1'b1) stable = 1'b0;
            if (res_vec() != '0) stray = 1'b1;
            if (bus.up_ready != '0) rdy_seen = 1'b1;
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    // Return a response after `delay` idle cycles; samples up_res one cycle later.
    task automatic resp_phase(input int delay, input logic [MM_DATA_WIDTH-1:0] data,
                              output logic [N-1:0] vmask,
                              output logic [N-1:0][MM_DATA_WIDTH-1:0] rd, output bit bad_wait);
        bad_wait = 1'b0;
        for (int c = 0; c <= delay; c++) begin
            if (c == delay) begin
                bus.mem_res.valid = 1'b1;
                bus.mem_res.rdata = data;
            end
            #1;
            if (bus.mem_req.valid || bus.up_ready != '0 || res_vec() != '0) bad_wait = 1'b1;
            tick();
        end
        bus.mem_res = '0;
        for (int i = 0; i < N; i++) begin
            vmask[i] = bus.up_res[i].valid;
            rd[i]    = bus.up_res[i].rdata;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < N; i++) bus.up_req[i] = mk_req(1'b0, $urandom, rand128());
        tick();
        #1;
        checks++;
        if (bus.up_ready !== '0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.up_ready);
        end
        checks++;
        if (bus.mem_req.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_valid: got %b want 0", bus.mem_req.valid);
        end
        checks++;
        if (res_vec() !== '0) begin
            errors++;
            $display("FAIL reset_res_valid: got %b want 0", res_vec());
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int idx, waited;
        logic [N-1:0] rdy, vmask;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
        do_reset();
        sb[2] = mk_req(1'b0, 32'h100, '0);
        bus.up_req[2] = sb[2];
        wait_accept(idx, rdy, waited, to);
        checks++;
        if (to || rdy !== 4'b0100 || waited != 0) begin
            errors++;
            $display("FAIL read_accept: got rdy=%b wait=%0d want rdy=0100 wait=0", rdy, waited);
            return;
        end
        issue_phase(0, first, stable, stray, rdy_seen);
        checks++;
        if (first !== sb[2] || !stable) begin
            errors++;
            $display("FAIL read_mem_req: got addr=%0h v=%b want addr=100 v=1", first.addr,
                     first.valid);
        end
        resp_phase(2, 128'hDEAD, vmask, rd, bad_wait);
        checks++;
        if (vmask !== 4'b0100 || rd[2] !== 128'hDEAD) begin
            errors++;
            $display("FAIL read_resp: got v=%b d=%0h want v=0100 d=dead", vmask, rd[2]);
        end
        checks++;
        if (bad_wait || stray || rdy_seen) begin
            errors++;
            $display("FAIL read_quiet: got %b%b%b want 000", bad_wait, stray, rdy_seen);
        end
        tick();
        checks++;
        if (res_vec() !== '0) begin
            errors++;
            $display("FAIL read_one_cycle: got %b want 0", res_vec());
        end
    endtask

    task automatic test_round_robin();
        int exp_tab [5];
        int idx, waited, exp_m;
        logic [N-1:0] rdy, vmask;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        logic [MM_DATA_WIDTH-1:0] data;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
`ifdef MM_ARB_FIXED_PRIO_EN
        exp_tab = '{0, 0, 0, 0, 0};
`else
        exp_tab = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        for (int i = 0; i < N; i++) begin
            sb[i] = mk_req(1'b0, $urandom, rand128());
            bus.up_req[i] = sb[i];
        end
        for (int n = 0; n < 5; n++) begin
            exp_m = model_pick(valid_vec());
            wait_accept(idx, rdy, waited, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL rr_accept: got timeout want grant %0d", exp_m);
                return;
            end
            checks++;
            if (idx != exp_m || idx != exp_tab[n]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", n, idx, exp_tab[n]);
            end
            checks++;
            if ($countones(rdy) != 1) begin
                errors++;
                $display("FAIL rr_onehot: got %b want one bit", rdy);
            end
            model_last = idx;
            bus.up_req[idx].valid = 1'b1;
            issue_phase($urandom_range(0, 2), first, stable, stray, rdy_seen);
            checks++;
            if (first !== sb[idx] || !stable || rdy_seen) begin
                errors++;
                $display("FAIL rr_issue: got addr=%0h rdy=%b want addr=%0h rdy=0", first.addr,
                         rdy_seen, sb[idx].addr);
            end
            data = rand128();
            resp_phase($urandom_range(0, 2), data, vmask, rd, bad_wait);
            checks++;
            if (vmask !== onehot(idx) || rd[idx] !== data) begin
                errors++;
                $display("FAIL rr_resp: got %b want %b", vmask, onehot(idx));
            end
        end
    endtask

    task automatic test_stall();
        int idx, waited;
        logic [N-1:0] rdy, vmask;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
        do_reset();
        sb[3] = mk_req(1'b0, 32'hCAFE0, rand128());
        bus.up_req[3] = sb[3];
        wait_accept(idx, rdy, waited, to);
        checks++;
        if (to || idx != 3) begin
            errors++;
            $display("FAIL stall_accept: got %0d want 3", idx);
            return;
        end
        issue_phase(5, first, stable, stray, rdy_seen);
        checks++;
        if (!stable || first !== sb[3]) begin
            errors++;
            $display("FAIL stall_stable: got stable=%b addr=%0h want 1 %0h", stable, first.addr,
                     sb[3].addr);
        end
        resp_phase(0, 128'h55, vmask, rd, bad_wait);
        checks++;
        if (bad_wait || vmask !== 4'b1000 || rd[3] !== 128'h55) begin
            errors++;
            $display("FAIL stall_resp: got v=%b bad=%b want v=1000 bad=0", vmask, bad_wait);
        end
    endtask

    task automatic test_reset_mid();
        int idx, waited;
        logic [N-1:0] rdy, vmask, seen;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
        do_reset();
        sb[1] = mk_req(1'b0, 32'h200, '0);
        bus.up_req[1] = sb[1];
        wait_accept(idx, rdy, waited, to);
        issue_phase(0, first, stable, stray, rdy_seen);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = N - 1;
        bus.mem_res = '{valid: 1'b1, rdata: 128'hBAD};
        tick();
        bus.mem_res = '0;
        seen = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            seen |= res_vec();
            tick();
        end
        checks++;
        if (seen !== '0) begin
            errors++;
            $display("FAIL rstmid_stale: got %b want 0", seen);
        end
        sb[0] = mk_req(1'b0, 32'h300, '0);
        bus.up_req[0] = sb[0];
        wait_accept(idx, rdy, waited, to);
        checks++;
        if (to || idx != 0 || waited != 0) begin
            errors++;
            $display("FAIL rstmid_idle: got idx=%0d wait=%0d want 0 0", idx, waited);
            return;
        end
        issue_phase(1, first, stable, stray, rdy_seen);
        resp_phase(1, 128'h77, vmask, rd, bad_wait);
        checks++;
        if (first !== sb[0] || vmask !== 4'b0001 || rd[0] !== 128'h77) begin
            errors++;
            $display("FAIL rstmid_service: got v=%b addr=%0h want 0001 300", vmask, first.addr);
        end
    endtask

    task automatic test_write();
        int idx, waited;
        logic [N-1:0] rdy, vmask;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
        do_reset();
        sb[1] = mk_req(1'b1, 32'h4440, rand128());
        bus.up_req[1] = sb[1];
        wait_accept(idx, rdy, waited, to);
        checks++;
        if (to || idx != 1) begin
            errors++;
            $display("FAIL write_accept: got %0d want 1", idx);
            return;
        end
        issue_phase(2, first, stable, stray, rdy_seen);
        checks++;
        if (first.we !== 1'b1 || first.wdata !== sb[1].wdata || first.addr !== sb[1].addr) begin
            errors++;
            $display("FAIL write_fields: got we=%b wdata=%0h want 1 %0h", first.we, first.wdata,
                     sb[1].wdata);
        end
        resp_phase(0, '0, vmask, rd, bad_wait);
        checks++;
        if (vmask !== 4'b0010) begin
            errors++;
            $display("FAIL write_ack: got %b want 0010", vmask);
        end
    endtask

    task automatic test_random();
        int idx, waited, exp_m;
        logic [N-1:0] rdy, vmask;
        logic [N-1:0][MM_DATA_WIDTH-1:0] rd;
        logic [MM_DATA_WIDTH-1:0] data;
        bit to, stable, stray, rdy_seen, bad_wait;
        mm_req_t first;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.up_req[i].valid && $urandom_range(0, 1) == 1) begin
                    sb[i] = mk_req(1'($urandom), $urandom, rand128());
                    bus.up_req[i] = sb[i];
                end
            end
            if (valid_vec() == '0) begin
                idx = $urandom_range(0, N - 1);
                sb[idx] = mk_req(1'($urandom), $urandom, rand128());
                bus.up_req[idx] = sb[idx];
            end
            exp_m = model_pick(valid_vec());
            // Stray memory response while idle must be ignored.
            if ($urandom_range(0, 2) == 0) bus.mem_res = '{valid: 1'b1, rdata: rand128()};
            wait_accept(idx, rdy, waited, to);
            bus.mem_res = '0;
            checks++;
            if (to || idx != exp_m || $countones(rdy) != 1) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want %0d", n, rdy, exp_m);
                return;
            end
            model_last = idx;
            issue_phase($urandom_range(0, 3), first, stable, stray, rdy_seen);
            checks++;
            if (first !== sb[idx] || !stable || stray || rdy_seen) begin
                errors++;
                $display("FAIL rand_issue[%0d]: got addr=%0h st=%b sr=%b want addr=%0h 1 0", n,
                         first.addr, stable, stray, sb[idx].addr);
            end
            data = rand128();
            resp_phase($urandom_range(0, 3), data, vmask, rd, bad_wait);
            checks++;
            if (vmask !== onehot(idx) || rd[idx] !== data || bad_wait) begin
                errors++;
                $display("FAIL rand_resp[%0d]: got v=%b bad=%b want v=%b bad=0", n, vmask,
                         bad_wait, onehot(idx));
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model_last = N - 1;
        rst        = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
